// File: rtl/seg7_pkg.sv
// seg7_pkg - shared constants for the multiplexed seven-segment driver.
//
// Contents:
//   SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit segment bus
//   SEG_BLANK            : a..g pattern for a dark digit
//   HEX_PATTERNS         : 16-entry hex-to-segment table (bit0 = a ... bit6 = g)

package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Glyphs 0-9, A, b, c, d, E, F.
    localparam logic [6:0] HEX_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode - combinational hex nibble to seven-segment pattern lookup.
//
// Ports:
//   nibble  : in  4  hex digit to display
//   pattern : out 7  segments a..g (bit0 = a), active-high

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_PATTERNS[nibble];

endmodule

// File: rtl/seg7_mux.sv
// seg7_mux - time-multiplexed driver for a DIGITS-digit seven-segment display.
//
// Each digit owns a slot of REFRESH_DIV clocks. The first clock of every slot
// is dark so the previous digit's segments never bleed into the next one.
// New display data is staged in a pending register and only promoted to the
// displayed shadow at a frame boundary, so a frame never shows two loads.
//
// Ports:
//   clk        : in  1         rising-edge clock
//   reset      : in  1         synchronous, active-high
//   en         : in  1         1 = scanning, 0 = blanked with the scan frozen
//   load       : in  1         strobe capturing value / dp / blank_lz
//   value      : in  4*DIGITS  hex nibbles, nibble k -> digit k
//   dp         : in  DIGITS    decimal point per digit
//   blank_lz   : in  1         leading-zero suppression
//   segments   : out 8         registered, bit0..6 = a..g, bit7 = dp
//   digit_sel  : out DIGITS    registered one-hot digit enable
//   frame_done : out 1         registered pulse after the last slot of a frame

module seg7_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // XOR masks that turn the internal active-high levels into pin levels.
    localparam logic [7:0]        SEG_INV  = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_INV  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_blz;
    logic                pend_valid;

    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic                shadow_blz;

    logic                slot_last;
    logic                frame_end;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_pattern;
    logic                lz_blank;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   sel_next;

    assign slot_last = (cnt == CNT_LAST);
    assign frame_end = en && slot_last && (idx == IDX_LAST);

    // Slot counter and digit index; both freeze while en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (slot_last) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Double buffering. A load landing exactly on the boundary goes straight to
    // the shadow; otherwise it waits in pending (last load wins) until the
    // next boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_blz     <= 1'b0;
            pend_valid   <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blz   <= 1'b0;
        end else if (load && frame_end) begin
            shadow_value <= value;
            shadow_dp    <= dp;
            shadow_blz   <= blank_lz;
            pend_valid   <= 1'b0;
        end else if (load) begin
            pend_value   <= value;
            pend_dp      <= dp;
            pend_blz     <= blank_lz;
            pend_valid   <= 1'b1;
        end else if (frame_end) begin
            if (pend_valid) begin
                shadow_value <= pend_value;
                shadow_dp    <= pend_dp;
                shadow_blz   <= pend_blz;
            end
            pend_valid <= 1'b0;
        end
    end

    assign cur_nibble = shadow_value[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    // A digit is a leading zero when it and every nibble above it are zero;
    // shifting the current digit down to bit 0 leaves exactly those nibbles.
    assign lz_blank = shadow_blz && (idx != '0) &&
                      ((shadow_value >> {idx, 2'b00}) == '0);

    // Dark during the guard cycle and while the scan is paused.
    always_comb begin
        seg_next = '0;
        sel_next = '0;
        if (en && (cnt != '0)) begin
            sel_next                = DIGITS'(1) << idx;
            seg_next[SEG_G:SEG_A]   = lz_blank ? SEG_BLANK : cur_pattern;
            seg_next[SEG_DP]        = shadow_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segments   <= SEG_INV;
            digit_sel  <= SEL_INV;
            frame_done <= 1'b0;
        end else begin
            segments   <= seg_next ^ SEG_INV;
            digit_sel  <= sel_next ^ SEL_INV;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_mux.sv
// tb_seg7_mux - self-checking bench for seg7_mux (DIGITS = 4, REFRESH_DIV = 4).
//
// Two instances share every input: one active-high, one ACTIVE_LOW. The
// reference model tracks a single position 0..15 inside the frame plus the
// displayed and pending data, and derives the expected pins from it.

module tb_seg7_mux;

    localparam int DIGITS    = 4;
    localparam int RDIV      = 4;
    localparam int FRAME_LEN = DIGITS * RDIV;

    // Expected digit0..digit3 for the leading-zero cases.
    localparam logic [7:0] LZ_WANT [3][4] = '{
        '{8'h3F, 8'h6D, 8'h00, 8'h00},
        '{8'h3F, 8'h00, 8'h00, 8'h00},
        '{8'h3F, 8'h00, 8'h80, 8'h00}
    };
    localparam logic [15:0] LZ_VAL [3] = '{16'h0050, 16'h0000, 16'h0000};
    localparam logic [3:0]  LZ_DP  [3] = '{4'b0000, 4'b0000, 4'b0100};

    logic        clk = 1'b0;
    logic        reset, en, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg, seg_n;
    logic [3:0]  sel, sel_n;
    logic        fd, fd_n;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int          m_pos, m_prev_pos;
    logic [15:0] m_val, m_pend_val;
    logic [3:0]  m_dp, m_pend_dp;
    logic        m_blz, m_pend_blz, m_pend_valid;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_sel;
    logic        exp_fd;

    always #5 clk = ~clk;

    seg7_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .value(value), .dp(dp),
        .blank_lz(blank_lz), .segments(seg), .digit_sel(sel), .frame_done(fd)
    );

    seg7_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .reset(reset), .en(en), .load(load), .value(value), .dp(dp),
        .blank_lz(blank_lz), .segments(seg_n), .digit_sel(sel_n), .frame_done(fd_n)
    );

    function automatic logic [6:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h67;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h58;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Drive one clock of inputs, advance the model across the same edge and
    // leave the expected pin values in exp_seg / exp_sel / exp_fd.
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [15:0] v, input logic [3:0] d, input logic b);
        int digit, slot, top;
        @(negedge clk);
        reset = r; en = e; load = l; value = v; dp = d; blank_lz = b;
        @(posedge clk);
        m_prev_pos = m_pos;
        if (r) begin
            m_pos = 0;
            m_val = '0; m_dp = '0; m_blz = 1'b0;
            m_pend_val = '0; m_pend_dp = '0; m_pend_blz = 1'b0; m_pend_valid = 1'b0;
            exp_seg = 8'h00; exp_sel = 4'h0; exp_fd = 1'b0;
        end else begin
            digit   = m_pos / RDIV;
            slot    = m_pos % RDIV;
            exp_seg = 8'h00;
            exp_sel = 4'h0;
            if (e && slot != 0) begin
                top = 0;
                for (int k = 0; k < DIGITS; k++)
                    if (m_val[4*k +: 4] != 4'h0) top = k;
                exp_sel    = 4'(1 << digit);
                exp_seg[6:0] = (m_blz && digit > top) ? 7'h00 : hex_pat(m_val[4*digit +: 4]);
                exp_seg[7] = m_dp[digit];
            end
            exp_fd = e && (m_pos == FRAME_LEN - 1);
            if (l && exp_fd) begin
                m_val = v; m_dp = d; m_blz = b; m_pend_valid = 1'b0;
            end else if (l) begin
                m_pend_val = v; m_pend_dp = d; m_pend_blz = b; m_pend_valid = 1'b1;
            end else if (exp_fd && m_pend_valid) begin
                m_val = m_pend_val; m_dp = m_pend_dp; m_blz = m_pend_blz; m_pend_valid = 1'b0;
            end
            if (e) m_pos = (m_pos + 1) % FRAME_LEN;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1);
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL reset_levels: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected 00/0000/0 and FF/1111",
                         seg, sel, fd, seg_n, sel_n);
            end
        end
        // Shadow is cleared, and the load held during reset must not appear.
        for (int i = 0; i < FRAME_LEN + 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL post_reset pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
        end
    endtask

    task automatic test_basic_frame();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h12AF, 4'h0, 1'b0);
        for (int i = 0; i < 2 * FRAME_LEN + 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL basic_frame pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
            if (m_prev_pos == 1) begin
                vectors++;
                if (seg !== 8'h71 || sel !== 4'b0001) begin
                    miscompares++;
                    $display("[TB] FAIL basic_digit0: got seg=%h sel=%b, expected 71/0001", seg, sel);
                end
            end
        end
    endtask

    task automatic test_blank_lz();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, LZ_VAL[c], LZ_DP[c], 1'b1);
            for (int i = 0; i < FRAME_LEN && m_pos != 0; i++)
                applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
            for (int i = 0; i < FRAME_LEN; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
                vectors++;
                if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                    miscompares++;
                    $display("[TB] FAIL blank_lz pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                             m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
                end
                if (m_prev_pos % RDIV == 1) begin
                    vectors++;
                    if (seg !== LZ_WANT[c][m_prev_pos / RDIV]) begin
                        miscompares++;
                        $display("[TB] FAIL blank_lz_case%0d digit%0d: got seg=%h, expected %h",
                                 c, m_prev_pos / RDIV, seg, LZ_WANT[c][m_prev_pos / RDIV]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic crossed;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
        for (int i = 0; i < FRAME_LEN && m_pos != 0; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        for (int i = 0; i < FRAME_LEN && m_pos != 5; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        // Second load lands in the digit1 slot of a frame showing 1111.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
        pulses  = 0;
        crossed = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
            if (fd === 1'b1) pulses++;
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL back_to_back pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
            if (m_prev_pos % RDIV == 1) begin
                vectors++;
                if (seg !== (crossed ? 8'h5B : 8'h06)) begin
                    miscompares++;
                    $display("[TB] FAIL frame_integrity pos=%0d: got seg=%h, expected %h",
                             m_prev_pos, seg, crossed ? 8'h5B : 8'h06);
                end
            end
            if (m_prev_pos == FRAME_LEN - 1) crossed = 1'b1;
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("[TB] FAIL frame_done_rate: got %0d pulses in 32 cycles, expected 2", pulses);
        end
    endtask

    task automatic test_enable();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h9876, 4'b1010, 1'b0);
        for (int i = 0; i < 2 * FRAME_LEN && !(m_pos == 10 && !m_pend_valid); i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            // Loads keep being accepted while paused.
            applyStimulus(1'b0, 1'b0, (i == 2), 16'h4444, 4'h1, 1'b0);
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0} ||
                {exp_seg, exp_sel, exp_fd} !== 13'h0) begin
                miscompares++;
                $display("[TB] FAIL paused: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected 00/0000/0",
                         seg, sel, fd, seg_n, sel_n);
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        vectors++;
        if (sel !== 4'b0100 || seg !== 8'h7F) begin
            miscompares++;
            $display("[TB] FAIL resume_cnt2: got seg=%h sel=%b, expected 7F/0100", seg, sel);
        end
        for (int i = 0; i < FRAME_LEN + 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL resume pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
        end
    endtask

    task automatic test_load_at_boundary();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hABCD, 4'h3, 1'b0);
        for (int i = 0; i < FRAME_LEN && m_pos != FRAME_LEN - 1; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        // The boundary load must override the pending one and show next frame.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0E07, 4'h8, 1'b1);
        for (int i = 0; i < FRAME_LEN + 1; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL boundary_load pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2 * FRAME_LEN && m_pos != 8; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h5678, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        vectors++;
        if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected 00/0000/0 and FF/1111",
                     seg, sel, fd, seg_n, sel_n);
        end
        for (int i = 0; i < FRAME_LEN + 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL after_reset_mid pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 1'($urandom));
            vectors++;
            if ({seg, sel, fd, seg_n, sel_n, fd_n} !== {exp_seg, exp_sel, exp_fd, ~exp_seg, ~exp_sel, exp_fd}) begin
                miscompares++;
                $display("[TB] FAIL random pos=%0d: got seg=%h sel=%b fd=%b inv_seg=%h inv_sel=%b, expected seg=%h sel=%b fd=%b",
                         m_prev_pos, seg, sel, fd, seg_n, sel_n, exp_seg, exp_sel, exp_fd);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0;
        m_pos = 0; m_prev_pos = 0;
        test_reset();
        test_basic_frame();
        test_blank_lz();
        test_back_to_back();
        test_enable();
        test_load_at_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_mux.md
SEG7_MUX -- requirements
Module: seg7_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 1000, clk cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; when 1, segments and digit_sel are inverted, including their reset and inactive levels.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port en  in  1  1 = scan running; 0 = display blanked and scan frozen.
REQ-007 SHALL have port load  in  1  one-cycle strobe that captures value, dp and blank_lz.
REQ-008 SHALL have port value  in  4*DIGITS  hex nibbles; nibble k drives digit k, with digit DIGITS-1 most significant.
REQ-009 SHALL have port dp  in  DIGITS  decimal point per digit.
REQ-010 SHALL have port blank_lz  in  1  leading-zero suppression enable.
REQ-011 SHALL have port segments  out  8  registered; bit0..bit6 = a..g, bit7 = dp.
REQ-012 SHALL have port digit_sel  out  DIGITS  registered one-hot digit enable.
REQ-013 SHALL have port frame_done  out  1  registered one-cycle pulse at the end of each frame.

Function
REQ-014 SHALL keep a slot counter cnt (0..REFRESH_DIV-1) and a digit index idx (0..DIGITS-1); cnt increments each enabled cycle and wraps to 0 at REFRESH_DIV-1, and idx increments on that wrap, going from DIGITS-1 back to 0.
REQ-015 SHALL drive outputs inactive (segments 0, digit_sel 0, before ACTIVE_LOW inversion) at cnt == 0 of every slot, as the anti-ghost guard.
REQ-016 SHALL drive digit_sel one-hot at bit idx and segments = pattern(shadow nibble idx) | (dp bit idx << 7) for cnt 1..REFRESH_DIV-1.
REQ-017 SHALL use these hex patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 b=7C c=58 d=5E E=79 F=71.
REQ-018 SHALL, when load is high, capture value/dp/blank_lz into a pending register and set pending_valid; if several loads occur in one frame, the last one wins.
REQ-019 SHALL define the frame boundary as the cycle where cnt == REFRESH_DIV-1 and idx == DIGITS-1; in that cycle it pulses frame_done and copies pending to shadow if pending_valid, then clears pending_valid.
REQ-020 SHALL, when load coincides with a frame boundary, write the load inputs directly into shadow and leave pending_valid clear.
REQ-021 SHALL leave the displayed shadow unchanged between boundaries, so no frame ever mixes two loads.
REQ-022 SHALL, with shadow blank_lz = 1, blank the segments a..g of every digit above the highest non-zero nibble; digit 0 is never suppressed, and dp bits still display.
REQ-023 SHALL, with en = 0, hold cnt and idx, drive outputs inactive and frame_done 0, and keep accepting loads; on en = 1 it resumes at the held cnt and idx.
REQ-024 SHALL register all outputs, with one cycle of latency from cnt/idx/shadow to the pins.

Reset
REQ-025 SHALL, while reset is high, clear cnt, idx, shadow, pending and pending_valid, set segments and digit_sel to their inactive levels, and set frame_done to 0.
REQ-026 SHALL give reset priority over load and en; a load in a reset cycle is discarded.
REQ-027 SHALL begin slot cnt = 0, idx = 0 in the first cycle after reset falls; reset mid-frame abandons the frame without a frame_done pulse.

Structure
REQ-028 SHALL place the segment bit positions, the 16-entry hex pattern table and the blank constant in shared package seg7_pkg.
REQ-029 SHALL implement the nibble-to-pattern lookup as combinational sub-module seg7_decode (4 bits in, 7 bits out, patterns per REQ-017), instantiated once on the muxed nibble.

Verification (DIGITS = 4, REFRESH_DIV = 4, ACTIVE_LOW = 0)
REQ-030 SHALL verify: reset, load 16'h12AF with dp 0 -> from the next frame, digit0 slot shows 0x71 with digit_sel 0001 at cnt 1..3 and 0/0 at cnt 0; digit1 shows 0x77, digit2 0x5B, digit3 0x06.
REQ-031 SHALL verify: blank_lz = 1, value 16'h0050 -> digits 3 and 2 show 0x00 while selected, digit1 shows 0x6D, digit0 shows 0x3F; value 16'h0000 -> only digit0 shows 0x3F.
REQ-032 SHALL verify: value 0, dp 4'b0100, blank_lz = 1 -> digit2 shows 0x80 and all other digits show 0x00 except digit0, which shows 0x3F.
REQ-033 SHALL verify: load 16'h1111 displayed, then load 16'h2222 during the digit1 slot -> digits 2 and 3 of that frame still show 0x06; the whole next frame shows 0x5B; frame_done pulses once per 16 cycles.
REQ-034 SHALL verify: en dropped at idx 2, cnt 2 for 5 cycles -> outputs 0, no frame_done; after en returns, the slot continues from cnt 2.
REQ-035 SHALL verify: reset asserted at idx 2 -> next cycle segments 0, digit_sel 0, shadow 0; with ACTIVE_LOW = 1 the same test yields segments 0xFF and digit_sel 4'b1111.
